// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types and lane helpers for the data memory responder
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ACC_BYTE    = 2'b00,
        ACC_HALF    = 2'b01,
        ACC_WORD    = 2'b10,
        ACC_ILLEGAL = 2'b11
    } mem_access_type_e;

    typedef enum logic [1:0] {
        MEM_OK         = 2'd0,
        MEM_MISALIGNED = 2'd1,
        MEM_ILLEGAL    = 2'd2,
        MEM_OOR        = 2'd3
    } mem_resp_status_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

    localparam int WAIT_CNT_W = 4;

    function automatic logic [3:0] be_from_access(input mem_access_type_e access, input logic [1:0] lane);
        logic [3:0] be;
        case (access)
            ACC_BYTE: be = 4'b0001 << lane;
            ACC_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            ACC_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; replicating it lets the byte enables pick the lane.
    function automatic logic [31:0] store_replicate(input logic [31:0] wdata, input mem_access_type_e access);
        logic [31:0] rep;
        case (access)
            ACC_BYTE: rep = {4{wdata[7:0]}};
            ACC_HALF: rep = {2{wdata[15:0]}};
            ACC_WORD: rep = wdata;
            default:  rep = 32'd0;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input mem_access_type_e access, input logic is_unsigned);
        logic [31:0] shifted;
        logic [31:0] ext;
        shifted = word >> {lane, 3'b000};
        case (access)
            ACC_BYTE: ext = is_unsigned ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            ACC_HALF: ext = is_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            ACC_WORD: ext = word;
            default:  ext = 32'd0;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - LSU-to-data-memory request/response channel
interface data_mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [1:0]        req_access;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [1:0]        rsp_status;

    modport master (
        output req_valid, req_addr, req_we, req_access, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_status
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_access, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_status
    );
endinterface

// File: rtl/data_mem_responder_bank.sv
// rtl/data_mem_responder_bank.sv - word array with byte write enables and combinational read
module data_mem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_q[idx];
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with wait states and lane steering
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave mem
);
    localparam int                    IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    resp_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  commit;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    mem_access_type_e  access_q;
    logic              unsigned_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    mem_resp_status_e  status_q;

    // With no wait states the commit happens on the accepting edge, so it must use the live request.
    logic              use_live;
    logic [ADDR_W-1:0] c_addr;
    logic              c_we;
    mem_access_type_e  c_access;
    logic              c_unsigned;
    logic [31:0]       c_wdata;

    assign use_live   = (state_q == ST_IDLE);
    assign c_addr     = use_live ? mem.req_addr : addr_q;
    assign c_we       = use_live ? mem.req_we : we_q;
    assign c_access   = use_live ? mem_access_type_e'(mem.req_access) : access_q;
    assign c_unsigned = use_live ? mem.req_unsigned : unsigned_q;
    assign c_wdata    = use_live ? mem.req_wdata : wdata_q;

    logic [ADDR_W-1:0] c_word_idx;
    logic              c_oor;
    mem_resp_status_e  c_status;

    assign c_word_idx = {2'b00, c_addr[ADDR_W-1:2]};
    assign c_oor      = (c_word_idx >= ADDR_W'(DEPTH_WORDS));

    always_comb begin
        c_status = MEM_OK;
        if (c_access == ACC_ILLEGAL) begin
            c_status = MEM_ILLEGAL;
        end else if ((c_access == ACC_HALF && c_addr[0]) ||
                     (c_access == ACC_WORD && c_addr[1:0] != 2'b00)) begin
            c_status = MEM_MISALIGNED;
        end else if (c_oor) begin
            c_status = MEM_OOR;
        end
    end

    logic [3:0]  bank_be;
    logic [31:0] bank_wdata;
    logic [31:0] bank_rdata;

    assign bank_be    = (commit && c_we && c_status == MEM_OK && !rst) ? be_from_access(c_access, c_addr[1:0]) : 4'b0000;
    assign bank_wdata = store_replicate(c_wdata, c_access);

    data_mem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk  (clk),
        .be   (bank_be),
        .idx  (c_addr[IDX_W+1:2]),
        .wdata(bank_wdata),
        .rdata(bank_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        commit        = 1'b0;
        mem.req_ready = (state_q == ST_IDLE) && !rst;
        mem.rsp_valid = (state_q == ST_RESP);
        case (state_q)
            ST_IDLE: begin
                if (mem.req_valid) begin
                    if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (mem.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            access_q   <= ACC_BYTE;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= MEM_OK;
        end else begin
            if (state_q == ST_IDLE && mem.req_valid) begin
                addr_q     <= mem.req_addr;
                we_q       <= mem.req_we;
                access_q   <= mem_access_type_e'(mem.req_access);
                unsigned_q <= mem.req_unsigned;
                wdata_q    <= mem.req_wdata;
            end
            if (commit) begin
                status_q <= c_status;
                rdata_q  <= (!c_we && c_status == MEM_OK) ?
                            load_extend(bank_rdata, c_addr[1:0], c_access, c_unsigned) : 32'd0;
            end
        end
    end

    assign mem.rsp_rdata  = rdata_q;
    assign mem.rsp_err    = (status_q != MEM_OK);
    assign mem.rsp_status = status_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder with one- and three-wait-state instances
module tb_data_mem_responder;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          sel;
    logic        rst_all, rst_sel;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_access;

    data_mem_responder_if #(.ADDR_W(32)) if_a ();
    data_mem_responder_if #(.ADDR_W(32)) if_b ();

    logic rst_a, rst_b;
    assign rst_a = rst_all || (rst_sel && sel == 0);
    assign rst_b = rst_all || (rst_sel && sel == 1);

    assign if_a.req_valid    = req_valid && sel == 0;
    assign if_a.rsp_ready    = rsp_ready && sel == 0;
    assign if_a.req_addr     = req_addr;
    assign if_a.req_we       = req_we;
    assign if_a.req_access   = req_access;
    assign if_a.req_unsigned = req_unsigned;
    assign if_a.req_wdata    = req_wdata;
    assign if_b.req_valid    = req_valid && sel == 1;
    assign if_b.rsp_ready    = rsp_ready && sel == 1;
    assign if_b.req_addr     = req_addr;
    assign if_b.req_we       = req_we;
    assign if_b.req_access   = req_access;
    assign if_b.req_unsigned = req_unsigned;
    assign if_b.req_wdata    = req_wdata;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_STATES(1)) u_ws1 (.clk(clk), .rst(rst_a), .mem(if_a));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst_b), .mem(if_b));

    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_status;
    assign o_req_ready  = (sel == 1) ? if_b.req_ready  : if_a.req_ready;
    assign o_rsp_valid  = (sel == 1) ? if_b.rsp_valid  : if_a.rsp_valid;
    assign o_rsp_err    = (sel == 1) ? if_b.rsp_err    : if_a.rsp_err;
    assign o_rsp_rdata  = (sel == 1) ? if_b.rsp_rdata  : if_a.rsp_rdata;
    assign o_rsp_status = (sel == 1) ? if_b.rsp_status : if_a.rsp_status;

    // Byte-addressed reference memory per instance; status codes 0 ok, 1 misaligned, 2 illegal, 3 out of range.
    logic [7:0] mb [2][DEPTH*4];

    function automatic void model_op(input int s, input logic [31:0] a, input logic w, input logic [1:0] acc,
                                     input logic u, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic e, output logic [1:0] st);
        int unsigned ua;
        int          size;
        logic [31:0] v;
        ua   = a;
        size = (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : (acc == 2'd2) ? 4 : 0;
        rd   = '0;
        v    = '0;
        if (size == 0)                  st = 2'd2;
        else if (ua % size != 0)        st = 2'd1;
        else if (ua / 4 >= DEPTH)       st = 2'd3;
        else                            st = 2'd0;
        e = (st != 2'd0);
        if (!e && w) begin
            for (int i = 0; i < size; i++) mb[s][ua + i] = wd[8*i +: 8];
        end
        if (!e && !w) begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = mb[s][ua + i];
            if (!u && size < 4 && v[8*size-1]) begin
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            rd = v;
        end
    endfunction

    task automatic do_req(input int s, input logic [31:0] a, input logic w, input logic [1:0] acc,
                          input logic u, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e, output logic [1:0] st, output int lat,
                          output logic [31:0] x_rd, output logic x_e, output logic [1:0] x_st);
        int guard;
        model_op(s, a, w, acc, u, wd, x_rd, x_e, x_st);
        sel = s; req_addr = a; req_we = w; req_access = acc; req_unsigned = u; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!o_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom); req_access = 2'($urandom_range(0, 3));
        lat = 0;
        while (!o_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (guard >= 20 || lat >= 40) lat = -1;
        rd = o_rsp_rdata; e = o_rsp_err; st = o_rsp_status;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_all = 1'b1; rst_sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; sel = 0;
        req_addr = '0; req_we = 1'b0; req_access = 2'd0; req_unsigned = 1'b0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            checks++;
            if (o_req_ready !== 1'b0 || o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'd0 || o_rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got ready=%b valid=%b rdata=%h err=%b expected 0 0 00000000 0",
                         s, o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err);
            end
        end
        rst_all = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            checks++;
            if (o_req_ready !== 1'b1) begin
                errors++; $display("FAIL ready_after_reset[%0d]: got %b expected 1", s, o_req_ready);
            end
        end
    endtask

    task automatic preclear();
        logic [31:0] rd, xr; logic e, xe; logic [1:0] st, xs; int lat;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DEPTH; w++)
                do_req(s, 32'(w * 4), 1'b1, 2'd2, 1'b0, 32'd0, rd, e, st, lat, xr, xe, xs);
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd, xr; logic e, xe; logic [1:0] st, xs; int lat;
        do_req(0, 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b0 || rd !== 32'd0 || lat != 1) begin
            errors++; $display("FAIL sw_word: got err=%b rdata=%h lat=%0d expected 0 00000000 1", e, rd, lat);
        end
        do_req(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b0 || rd !== 32'hDEADBEEF || lat != 1) begin
            errors++; $display("FAIL lw_word: got err=%b rdata=%h lat=%0d expected 0 deadbeef 1", e, rd, lat);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, xr; logic e, xe; logic [1:0] st, xs; int lat;
        do_req(0, 32'h21, 1'b1, 2'd0, 1'b0, {24'($urandom), 8'h80}, rd, e, st, lat, xr, xe, xs);
        do_req(0, 32'h21, 1'b0, 2'd0, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b0 || rd !== 32'hFFFFFF80) begin
            errors++; $display("FAIL lb_signed: got err=%b rdata=%h expected 0 ffffff80", e, rd);
        end
        do_req(0, 32'h21, 1'b0, 2'd0, 1'b1, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b0 || rd !== 32'h00000080) begin
            errors++; $display("FAIL lbu: got err=%b rdata=%h expected 0 00000080", e, rd);
        end
        do_req(0, 32'h20, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b0 || rd !== 32'h00008000) begin
            errors++; $display("FAIL lw_after_sb: got err=%b rdata=%h expected 0 00008000", e, rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd, xr; logic e, xe; logic [1:0] st, xs; int lat;
        do_req(0, 32'h32, 1'b1, 2'd1, 1'b0, {16'($urandom), 16'h1234}, rd, e, st, lat, xr, xe, xs);
        do_req(0, 32'h30, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b0 || rd !== 32'h12340000) begin
            errors++; $display("FAIL lw_after_sh: got err=%b rdata=%h expected 0 12340000", e, rd);
        end
        do_req(0, 32'h31, 1'b0, 2'd1, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0 || st !== 2'd1) begin
            errors++; $display("FAIL lh_misaligned: got err=%b rdata=%h status=%0d expected 1 00000000 1", e, rd, st);
        end
        do_req(0, 32'h30, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (rd !== 32'h12340000) begin
            errors++; $display("FAIL lw_after_bad_lh: got %h expected 12340000", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, xr; logic e, xe; logic [1:0] st, xs; int lat;
        do_req(0, 32'h6, 1'b1, 2'd2, 1'b0, 32'h55555555, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b1 || st !== 2'd1 || rd !== 32'd0) begin
            errors++; $display("FAIL sw_misaligned: got err=%b status=%0d rdata=%h expected 1 1 00000000", e, st, rd);
        end
        do_req(0, 32'h4, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (rd !== 32'd0 || e !== 1'b0) begin
            errors++; $display("FAIL no_write_misaligned: got err=%b rdata=%h expected 0 00000000", e, rd);
        end
        do_req(0, 32'h8, 1'b1, 2'd3, 1'b0, 32'hFFFFFFFF, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b1 || st !== 2'd2) begin
            errors++; $display("FAIL store_illegal: got err=%b status=%0d expected 1 2", e, st);
        end
        do_req(0, 32'h8, 1'b0, 2'd3, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0 || st !== 2'd2) begin
            errors++; $display("FAIL load_illegal: got err=%b rdata=%h status=%0d expected 1 00000000 2", e, rd, st);
        end
        do_req(0, 32'h8, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL no_write_illegal: got %h expected 00000000", rd);
        end
        do_req(0, 32'(DEPTH * 4), 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0 || st !== 2'd3) begin
            errors++; $display("FAIL lw_oor: got err=%b rdata=%h status=%0d expected 1 00000000 3", e, rd, st);
        end
        do_req(0, 32'h80000010, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (e !== 1'b1 || st !== 2'd3) begin
            errors++; $display("FAIL lw_oor_high: got err=%b status=%0d expected 1 3", e, st);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        sel = 0; req_addr = 32'h10; req_we = 1'b0; req_access = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        guard = 0;
        while (!o_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!o_rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        checks++;
        if (o_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_response: got valid=%b expected 1", o_rsp_valid);
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_access = 2'd2; req_wdata = $urandom;
            req_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            @(posedge clk); #1;
            checks++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'hDEADBEEF || o_rsp_err !== 1'b0 || o_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b expected 1 deadbeef 0 0",
                         i, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready);
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: got ready=%b valid=%b expected 1 0", o_req_ready, o_rsp_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, xr, a; logic e, xe; logic [1:0] st, xs, acc; int lat, s;
        for (int n = 0; n < 120; n++) begin
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0:       a = 32'(DEPTH * 4 + $urandom_range(0, 15));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, DEPTH * 4 - 1));
            endcase
            acc = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(s, a, 1'($urandom), acc, 1'($urandom), $urandom, rd, e, st, lat, xr, xe, xs);
            checks++;
            if (rd !== xr || e !== xe || st !== xs || lat != (s == 1 ? 3 : 1)) begin
                errors++;
                $display("FAIL random[%0d] ws%0d addr=%h acc=%0d: got rdata=%h err=%b status=%0d lat=%0d expected %h %b %0d %0d",
                         n, (s == 1 ? 3 : 1), a, acc, rd, e, st, lat, xr, xe, xs, (s == 1 ? 3 : 1));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd, xr; logic e, xe; logic [1:0] st, xs; int lat, guard; logic seen;
        do_req(1, 32'h40, 1'b1, 2'd2, 1'b0, 32'h11223344, rd, e, st, lat, xr, xe, xs);
        sel = 1; req_addr = 32'h40; req_we = 1'b1; req_access = 2'd2; req_wdata = 32'hAAAAAAAA; req_valid = 1'b1;
        guard = 0;
        while (!o_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0; rst_sel = 1'b1; #1;
        checks++;
        if (o_req_ready !== 1'b0) begin
            errors++; $display("FAIL ready_in_reset: got %b expected 0", o_req_ready);
        end
        @(posedge clk); #1;
        rst_sel = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin seen |= o_rsp_valid; @(posedge clk); #1; end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_wait_no_rsp: got valid seen=%b expected 0", seen);
        end
        do_req(1, 32'h40, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (rd !== 32'h11223344 || rd !== xr) begin
            errors++; $display("FAIL store_dropped: got %h expected 11223344", rd);
        end

        model_op(1, 32'h40, 1'b1, 2'd2, 1'b0, 32'hAAAAAAAA, xr, xe, xs);
        req_addr = 32'h40; req_we = 1'b1; req_access = 2'd2; req_wdata = 32'hAAAAAAAA; req_valid = 1'b1;
        guard = 0;
        while (!o_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!o_rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        rst_sel = 1'b1;
        @(posedge clk); #1;
        rst_sel = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin seen |= o_rsp_valid; @(posedge clk); #1; end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_resp_discarded: got valid seen=%b expected 0", seen);
        end
        do_req(1, 32'h40, 1'b0, 2'd2, 1'b0, 32'h0, rd, e, st, lat, xr, xe, xs);
        checks++;
        if (rd !== 32'hAAAAAAAA) begin
            errors++; $display("FAIL store_persisted: got %h expected aaaaaaaa", rd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH * 4; i++) mb[s][i] = 8'h00;
        test_reset();
        preclear();
        test_word_store_load();
        test_byte_lanes();
        test_half();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
